// File: rtl/mem_fifo_stage_if.sv
// Memory request channel: valid/ready handshake plus one request payload.
interface mem_fifo_stage_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 1
);
   logic                  valid;
   logic                  ready;
   logic                  read_enable;
   logic [MASK_WIDTH-1:0] write_enable;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic [ID_WIDTH-1:0]   id;

   modport master (
      output valid, read_enable, write_enable, addr, data, id,
      input  ready
   );

   modport slave (
      input  valid, read_enable, write_enable, addr, data, id,
      output ready
   );
endinterface

// File: rtl/mem_fifo_stage.sv
// In-order multi-entry buffer for memory requests with occupancy, flush and
// optional zero-latency fall-through when empty.
module mem_fifo_stage #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH     = 1,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned FALL_THROUGH = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   mem_fifo_stage_if.slave              mem_in,
   mem_fifo_stage_if.master             mem_out,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned COUNT_WIDTH = $clog2(DEPTH + 1);
   localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);

   typedef struct packed {
      logic                  read_enable;
      logic [MASK_WIDTH-1:0] write_enable;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [ID_WIDTH-1:0]   id;
   } entry_t;

   entry_t                 mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   entry_t in_entry;
   entry_t head;
   logic   empty, full, bypass, in_ready, out_valid;
   logic   push, pop, store, drain;

   always_comb begin
      in_entry = '{read_enable:  mem_in.read_enable,
                   write_enable: mem_in.write_enable,
                   addr:         mem_in.addr,
                   data:         mem_in.data,
                   id:           mem_in.id};

      empty     = (count_q == '0);
      full      = (count_q == COUNT_WIDTH'(DEPTH));
      // Ready depends only on registered state, never on the consumer.
      in_ready  = !full && !flush;
      bypass    = (FALL_THROUGH != 0) && empty && mem_in.valid && !flush;
      out_valid = (!empty && !flush) || bypass;

      push  = mem_in.valid && in_ready;
      pop   = out_valid && mem_out.ready;
      // A bypassed request consumed in the same cycle never enters storage.
      store = push && !(bypass && mem_out.ready);
      drain = pop && !empty;

      head = '0;
      if (bypass) begin
         head = in_entry;
      end else if (out_valid) begin
         head = mem_q[rd_ptr_q];
      end

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (store) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         if (drain) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         if (store && !drain) begin
            count_d = count_q + COUNT_WIDTH'(1);
         end else if (drain && !store) begin
            count_d = count_q - COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   assign mem_in.ready         = in_ready;
   assign mem_out.valid        = out_valid;
   assign mem_out.read_enable  = head.read_enable;
   assign mem_out.write_enable = head.write_enable;
   assign mem_out.addr         = head.addr;
   assign mem_out.data         = head.data;
   assign mem_out.id           = head.id;
   assign count                = count_q;
endmodule

// File: tb/tb_mem_fifo_stage.sv
// Directed bench for mem_fifo_stage: registered instance checked through a
// scoreboard queue, fall-through instance checked directly.
module tb_mem_fifo_stage;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;
   localparam int unsigned IW = 4;

   typedef logic [72:0] ent_t;  // {read_enable, write_enable, addr, data, id}

   logic        clk = 1'b0;
   logic        rst;
   logic        flush0, flush1;
   logic [2:0]  count0, count1;
   int unsigned cmp_cnt = 0;
   int unsigned err_cnt = 0;
   ent_t        sb[$];
   bit          acc0;
   int unsigned recv0;

   mem_fifo_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)) in0 ();
   mem_fifo_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)) out0 ();
   mem_fifo_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)) in1 ();
   mem_fifo_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)) out1 ();

   mem_fifo_stage #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW),
      .DEPTH(4), .FALL_THROUGH(0)
   ) dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .mem_in(in0), .mem_out(out0), .count(count0)
   );

   mem_fifo_stage #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW),
      .DEPTH(4), .FALL_THROUGH(1)
   ) dut1 (
      .clk(clk), .rst(rst), .flush(flush1), .mem_in(in1), .mem_out(out1), .count(count1)
   );

   always #5 clk = ~clk;

   function automatic ent_t mk(logic re, logic [3:0] we, logic [31:0] a, logic [31:0] d,
                               logic [3:0] id);
      return {re, we, a, d, id};
   endfunction

   function automatic ent_t out0_ent();
      return mk(out0.read_enable, out0.write_enable, out0.addr, out0.data, out0.id);
   endfunction

   function automatic ent_t out1_ent();
      return mk(out1.read_enable, out1.write_enable, out1.addr, out1.data, out1.id);
   endfunction

   task automatic check(input string tag, input ent_t obs, input ent_t exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive0(input bit v, input ent_t e);
      in0.valid        = v;
      in0.read_enable  = e[72];
      in0.write_enable = e[71:68];
      in0.addr         = e[67:36];
      in0.data         = e[35:4];
      in0.id           = e[3:0];
   endtask

   task automatic drive1(input bit v, input ent_t e);
      in1.valid        = v;
      in1.read_enable  = e[72];
      in1.write_enable = e[71:68];
      in1.addr         = e[67:36];
      in1.data         = e[35:4];
      in1.id           = e[3:0];
   endtask

   // Sample handshakes of dut0 on the falling edge, then advance past the next rising edge.
   task automatic tick();
      ent_t exp;
      @(negedge clk);
      acc0 = in0.valid && in0.ready;
      if (acc0) sb.push_back(mk(in0.read_enable, in0.write_enable, in0.addr, in0.data, in0.id));
      if (out0.valid && out0.ready) begin
         if (sb.size() == 0) begin
            cmp_cnt++;
            assert (sb.size() != 0) else begin
               err_cnt++;
               $error("FAIL sb_underflow: observed pop of %h expected no output", out0_ent());
            end
         end else begin
            exp = sb.pop_front();
            check("sb_order", out0_ent(), exp);
            recv0++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      ent_t e;
      int unsigned sent, cyc;

      rst = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
      drive0(1'b0, '0); drive1(1'b0, '0);
      out0.ready = 1'b0; out1.ready = 1'b0;
      recv0 = 0;
      @(posedge clk); #1;
      tick();
      rst = 1'b0;
      tick();

      check("rst_count0", 73'(count0), 73'(0));
      check("rst_valid0", 73'(out0.valid), 73'(0));
      check("rst_ready0", 73'(in0.ready), 73'(1));
      check("rst_payload0", out0_ent(), '0);
      check("rst_count1", 73'(count1), 73'(0));

      // Fill without a consumer.
      for (int k = 0; k < 4; k++) begin
         drive0(1'b1, mk(1'b0, 4'(k + 1), 32'h10 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 4'(k)));
         tick();
      end
      check("full_count", 73'(count0), 73'(4));
      check("full_ready", 73'(in0.ready), 73'(0));
      drive0(1'b1, mk(1'b1, 4'h0, 32'h20, 32'h5555_AAAA, 4'h4));
      tick();
      check("pending_count", 73'(count0), 73'(4));
      check("head_stable", 73'(out0.addr), 73'(32'h10));

      // Full with a simultaneous pop: only the pop happens.
      out0.ready = 1'b1;
      tick();
      check("full_pop_count", 73'(count0), 73'(3));
      out0.ready = 1'b0;
      tick();
      check("refill_count", 73'(count0), 73'(4));
      drive0(1'b0, '0);
      out0.ready = 1'b1;
      cyc = 0;
      while (count0 != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("drain_count", 73'(count0), 73'(0));
      check("drain_sb", 73'(sb.size()), 73'(0));

      // Stream ten ids with random stalls on both sides.
      sent = 0; recv0 = 0; cyc = 0;
      while (recv0 < 10 && cyc < 300) begin
         if (sent < 10 && $urandom_range(0, 3) != 0) begin
            drive0(1'b1, mk(sent[0], 4'(sent), 32'h100 + 32'(sent * 4), 32'hA000_0000 | 32'(sent),
                            4'(sent)));
         end else begin
            drive0(1'b0, '0);
         end
         out0.ready = ($urandom_range(0, 2) != 0);
         tick();
         if (acc0) sent++;
         cyc++;
      end
      drive0(1'b0, '0);
      out0.ready = 1'b0;
      check("stream_recv", 73'(recv0), 73'(10));
      check("stream_sb", 73'(sb.size()), 73'(0));
      check("stream_count", 73'(count0), 73'(0));

      // Flush with three entries stored and a request pending.
      for (int k = 0; k < 3; k++) begin
         drive0(1'b1, mk(1'b0, 4'hF, 32'h200 + 32'(k * 4), 32'(k), 4'(k)));
         tick();
      end
      drive0(1'b0, '0);
      check("pre_flush_count", 73'(count0), 73'(3));
      flush0 = 1'b1;
      out0.ready = 1'b1;
      drive0(1'b1, mk(1'b1, 4'h0, 32'h300, 32'h0, 4'h7));
      #1;
      check("flush_in_ready", 73'(in0.ready), 73'(0));
      check("flush_out_valid", 73'(out0.valid), 73'(0));
      tick();
      flush0 = 1'b0;
      drive0(1'b0, '0);
      out0.ready = 1'b0;
      sb.delete();
      check("post_flush_count", 73'(count0), 73'(0));
      check("post_flush_valid", 73'(out0.valid), 73'(0));

      // Asynchronous reset in the middle of a clock period.
      for (int k = 0; k < 2; k++) begin
         drive0(1'b1, mk(1'b1, 4'h0, 32'h400 + 32'(k * 4), 32'h0, 4'(k)));
         tick();
      end
      drive0(1'b0, '0);
      check("pre_rst_count", 73'(count0), 73'(2));
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 73'(out0.valid), 73'(0));
      check("async_rst_count", 73'(count0), 73'(0));
      sb.delete();
      #1 rst = 1'b0;
      @(posedge clk); #1;
      e = mk(1'b0, 4'h3, 32'h80, 32'h1234_5678, 4'h9);
      drive0(1'b1, e);
      check("ft0_no_bypass", 73'(out0.valid), 73'(0));
      tick();
      drive0(1'b0, '0);
      check("rst_sole_count", 73'(count0), 73'(1));
      check("rst_sole_head", out0_ent(), e);
      out0.ready = 1'b1;
      tick();
      out0.ready = 1'b0;
      check("rst_sole_drain", 73'(count0), 73'(0));

      // Fall-through instance: same-cycle pass, then stored when the consumer stalls.
      e = mk(1'b0, 4'hF, 32'h40, 32'hDEAD_BEEF, 4'h5);
      out1.ready = 1'b1;
      drive1(1'b1, e);
      #1;
      check("ft_bypass_valid", 73'(out1.valid), 73'(1));
      check("ft_bypass_payload", out1_ent(), e);
      tick();
      check("ft_bypass_count", 73'(count1), 73'(0));
      e = mk(1'b1, 4'h0, 32'h44, 32'hCAFE_F00D, 4'h6);
      out1.ready = 1'b0;
      drive1(1'b1, e);
      #1;
      check("ft_stall_valid", 73'(out1.valid), 73'(1));
      tick();
      drive1(1'b0, '0);
      check("ft_store_count", 73'(count1), 73'(1));
      check("ft_store_payload", out1_ent(), e);
      tick();
      check("ft_hold_payload", out1_ent(), e);
      out1.ready = 1'b1;
      tick();
      check("ft_drain_count", 73'(count1), 73'(0));
      check("ft_drain_valid", 73'(out1.valid), 73'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
